// File: rtl/tlc_phase_scheduler.sv
// rtl/tlc_phase_scheduler.sv - 4-way right-of-way scheduler
// Round-robin service with emergency preemption; sequences GREEN/YELLOW/ALLRED timing.
module tlc_phase_scheduler #(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] emergency,
   input  logic [3:0] jam,
   input  logic [3:0] empty,
   output logic [3:0] grant,
   output logic [1:0] phase,
   output logic       preempt,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_GREEN  = 2'b01,
      S_YELLOW = 2'b10,
      S_ALLRED = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] YEL_C = CNT_W'(YELLOW_T);
   localparam logic [CNT_W-1:0] AR_C  = CNT_W'(ALLRED_T);

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [3:0]       pend_q, pend_d;
   logic [3:0]       epend_q, epend_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       rr_q, rr_d;
   logic             preempt_q, preempt_d;
   logic             busy_q, busy_d;

   logic [1:0]       win_idx;
   logic [1:0]       cand;
   logic             win_any;
   logic [3:0]       others;
   logic [3:0]       consume;
   logic             go_green;
   logic             to_yellow;

   assign grant   = grant_q;
   assign phase   = state_q;
   assign preempt = preempt_q;
   assign busy    = busy_q;

   // Emergencies win by lowest index; otherwise search starts just after the last served approach.
   always_comb begin
      win_idx = 2'd0;
      cand    = 2'd0;
      win_any = |(pend_q | epend_q);
      if (|epend_q) begin
         for (int k = 3; k >= 0; k--) begin
            if (epend_q[k]) win_idx = 2'(k);
         end
      end else begin
         for (int i = 4; i >= 1; i--) begin
            cand = rr_q + 2'(i);
            if (pend_q[cand]) win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      timer_d   = timer_q;
      rr_d      = rr_q;
      preempt_d = 1'b0;
      go_green  = 1'b0;
      to_yellow = 1'b0;
      consume   = 4'b0000;
      others    = (pend_q | epend_q) & ~grant_q;
      case (state_q)
         S_IDLE: go_green = win_any;
         S_GREEN: begin
            consume = grant_q;
            if (timer_q != MAX_C) timer_d = timer_q + ONE_C;
            if (|((emergency | epend_q) & grant_q)) begin
               to_yellow = 1'b0;
            end else if (|(epend_q & ~grant_q)) begin
               to_yellow = 1'b1;
               preempt_d = 1'b1;
            end else if (timer_q >= MIN_C &&
                         ((|(empty & grant_q)) || (others != 4'b0000 && !(|(jam & grant_q))))) begin
               to_yellow = 1'b1;
            end else if (timer_q >= MAX_C && others != 4'b0000) begin
               to_yellow = 1'b1;
            end
            if (to_yellow) begin
               state_d = S_YELLOW;
               timer_d = ONE_C;
            end
         end
         S_YELLOW: begin
            if (timer_q >= YEL_C) begin
               state_d = S_ALLRED;
               grant_d = 4'b0000;
               timer_d = ONE_C;
            end else begin
               timer_d = timer_q + ONE_C;
            end
         end
         S_ALLRED: begin
            if (timer_q >= AR_C) begin
               if (win_any) begin
                  go_green = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end
            end else begin
               timer_d = timer_q + ONE_C;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Entering green consumes the winner's request, including one arriving this same cycle.
      if (go_green) begin
         state_d = S_GREEN;
         grant_d = 4'b0001 << win_idx;
         rr_d    = win_idx;
         timer_d = ONE_C;
         consume = 4'b0001 << win_idx;
      end
      pend_d  = (pend_q | req | jam) & ~empty & ~consume;
      epend_d = (epend_q | emergency) & ~empty & ~consume;
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         grant_q   <= 4'b0000;
         pend_q    <= 4'b0000;
         epend_q   <= 4'b0000;
         timer_q   <= '0;
         rr_q      <= 2'd3;
         preempt_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pend_q    <= pend_d;
         epend_q   <= epend_d;
         timer_q   <= timer_d;
         rr_q      <= rr_d;
         preempt_q <= preempt_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb/tb_tlc_phase_scheduler.sv - self-checking bench for tlc_phase_scheduler
// Reference model tracks phase/age/pending sets; outputs compared every cycle plus directed literals.
module tb_tlc_phase_scheduler;

   localparam int MIN_GREEN = 4;
   localparam int MAX_GREEN = 12;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, emergency, jam, empty;
   logic [3:0] grant;
   logic [1:0] phase;
   logic       preempt, busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   int m_ph  = 0;
   int m_cur = 0;
   int m_rr  = 3;
   int m_age = 0;
   bit m_pre = 1'b0;
   bit m_pend [4];
   bit m_ep   [4];

   tlc_phase_scheduler #(
      .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .emergency(emergency), .jam(jam), .empty(empty),
      .grant(grant), .phase(phase), .preempt(preempt), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int pick();
      for (int k = 0; k < 4; k++) if (m_ep[k]) return k;
      for (int d = 1; d <= 4; d++) if (m_pend[(m_rr + d) % 4]) return (m_rr + d) % 4;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      int nph;
      bit start_green;
      bit pre;
      bit others;
      bit other_ep;
      if (rst) begin
         m_ph = 0; m_cur = 0; m_rr = 3; m_age = 0; m_pre = 1'b0;
         for (int k = 0; k < 4; k++) begin m_pend[k] = 1'b0; m_ep[k] = 1'b0; end
         return;
      end
      w = pick();
      nph = m_ph;
      start_green = 1'b0;
      pre = 1'b0;
      others = 1'b0;
      other_ep = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k != m_cur && (m_pend[k] || m_ep[k])) others = 1'b1;
         if (k != m_cur && m_ep[k]) other_ep = 1'b1;
      end
      case (m_ph)
         0: start_green = (w >= 0);
         1: begin
            if (emergency[m_cur]) nph = 1;
            else if (other_ep) begin nph = 2; pre = 1'b1; end
            else if (m_age >= MIN_GREEN && (empty[m_cur] || (others && !jam[m_cur]))) nph = 2;
            else if (m_age >= MAX_GREEN && others) nph = 2;
         end
         2: if (m_age == YELLOW_T) nph = 3;
         default: if (m_age == ALLRED_T) begin
            if (w >= 0) start_green = 1'b1;
            else nph = 0;
         end
      endcase
      for (int k = 0; k < 4; k++) begin
         if (req[k] || jam[k]) m_pend[k] = 1'b1;
         if (emergency[k]) m_ep[k] = 1'b1;
         if (empty[k] || (m_ph == 1 && k == m_cur) || (start_green && k == w)) begin
            m_pend[k] = 1'b0;
            m_ep[k]   = 1'b0;
         end
      end
      m_pre = pre;
      if (start_green) begin
         m_ph = 1; m_cur = w; m_rr = w; m_age = 1;
      end else if (nph != m_ph) begin
         m_ph = nph; m_age = 1;
      end else begin
         m_age++;
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      logic [3:0] eg;
      logic [1:0] ep;
      eg = (m_ph == 1 || m_ph == 2) ? 4'(1 << m_cur) : 4'b0000;
      ep = 2'(m_ph);
      if (chk_en) begin
         n_checks++;
         if (grant === eg && phase === ep && preempt === m_pre && busy === (m_ph != 0))
            n_pass++;
         else
            $display("FAIL cycle_outputs t=%0t actual grant=%b phase=%b preempt=%b busy=%b required grant=%b phase=%b preempt=%b busy=%b",
                     $time, grant, phase, preempt, busy, eg, ep, m_pre, (m_ph != 0));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] p, input logic pr);
      n_checks++;
      if (grant === g && phase === p && preempt === pr && busy === (p != 2'b00))
         n_pass++;
      else
         $display("FAIL %s actual grant=%b phase=%b preempt=%b busy=%b required grant=%b phase=%b preempt=%b busy=%b",
                  name, grant, phase, preempt, busy, g, p, pr, (p != 2'b00));
   endtask

   task automatic do_reset();
      req = 4'b0; emergency = 4'b0; jam = 4'b0; empty = 4'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0; emergency = 4'b0; jam = 4'b0; empty = 4'b0;
      step(2);
      chk_en = 1'b1;

      // single request, then indefinite rest
      do_reset();
      expect_out("reset_state", 4'b0000, 2'b00, 1'b0);
      req = 4'b0001; step(1); req = 4'b0000; step(1);
      expect_out("first_grant", 4'b0001, 2'b01, 1'b0);
      step(55);
      expect_out("green_rest", 4'b0001, 2'b01, 1'b0);

      // N and E together: min green, yellow, all-red, then E
      do_reset();
      req = 4'b0101; step(1); req = 4'b0000; step(1);
      expect_out("ne_green1", 4'b0001, 2'b01, 1'b0);
      step(3);
      expect_out("ne_green4", 4'b0001, 2'b01, 1'b0);
      step(1);
      expect_out("ne_yellow1", 4'b0001, 2'b10, 1'b0);
      step(2);
      expect_out("ne_yellow3", 4'b0001, 2'b10, 1'b0);
      step(1);
      expect_out("ne_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("e_green", 4'b0100, 2'b01, 1'b0);
      step(12);

      // emergency S at N timer 2
      do_reset();
      req = 4'b0001; step(1); req = 4'b0000; step(2);
      emergency = 4'b0010; step(1); emergency = 4'b0000;
      expect_out("pre_latched", 4'b0001, 2'b01, 1'b0);
      step(1);
      expect_out("pre_pulse", 4'b0001, 2'b10, 1'b1);
      step(1);
      expect_out("pre_pulse_end", 4'b0001, 2'b10, 1'b0);
      step(2);
      expect_out("pre_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("pre_s_green", 4'b0010, 2'b01, 1'b0);
      step(6);

      // emergency during yellow does not shorten clearance, wins arbitration over pending E
      do_reset();
      req = 4'b0101; step(1); req = 4'b0000; step(5);
      emergency = 4'b0010; step(1); emergency = 4'b0000;
      expect_out("yel_em_y2", 4'b0001, 2'b10, 1'b0);
      step(1);
      expect_out("yel_em_y3", 4'b0001, 2'b10, 1'b0);
      step(1);
      expect_out("yel_em_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("yel_em_s_green", 4'b0010, 2'b01, 1'b0);
      step(16);

      // jam holds N to MAX_GREEN against a pending S
      do_reset();
      req = 4'b0001; jam = 4'b0001; step(1); req = 4'b0000; step(1);
      req = 4'b0010; step(1); req = 4'b0000;
      step(9);
      expect_out("jam_green11", 4'b0001, 2'b01, 1'b0);
      step(1);
      expect_out("jam_green12", 4'b0001, 2'b01, 1'b0);
      step(1);
      expect_out("jam_yellow", 4'b0001, 2'b10, 1'b0);
      step(3);
      expect_out("jam_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("jam_s_green", 4'b0010, 2'b01, 1'b0);
      jam = 4'b0000;
      step(14);

      // empty cancels a same-cycle request; empty ends a lone green
      do_reset();
      req = 4'b1000; empty = 4'b1000; step(1); req = 4'b0000; empty = 4'b0000;
      step(2);
      expect_out("empty_wins", 4'b0000, 2'b00, 1'b0);
      req = 4'b1000; step(1); req = 4'b0000; step(5);
      empty = 4'b1000; step(1); empty = 4'b0000;
      expect_out("w_empty_yellow", 4'b1000, 2'b10, 1'b0);
      step(3);
      expect_out("w_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("w_idle", 4'b0000, 2'b00, 1'b0);

      // reset during yellow discards pending S/E
      do_reset();
      req = 4'b0111; step(1); req = 4'b0000; step(5);
      rst = 1'b1; step(1); rst = 1'b0;
      expect_out("rst_mid", 4'b0000, 2'b00, 1'b0);
      step(10);
      expect_out("rst_stays_idle", 4'b0000, 2'b00, 1'b0);

      // two emergencies together: lower index first, the other preempts next
      do_reset();
      req = 4'b0001; step(1); req = 4'b0000; step(1);
      emergency = 4'b0110; step(1); emergency = 4'b0000;
      step(1);
      expect_out("dual_pre1", 4'b0001, 2'b10, 1'b1);
      step(3);
      expect_out("dual_allred", 4'b0000, 2'b11, 1'b0);
      step(1);
      expect_out("dual_s_green", 4'b0010, 2'b01, 1'b0);
      step(1);
      expect_out("dual_pre2", 4'b0010, 2'b10, 1'b1);
      step(5);
      expect_out("dual_e_green", 4'b0100, 2'b01, 1'b0);
      step(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Right-of-way scheduler for the 4-way intersection. It latches per-approach service requests and picks the next approach by round-robin, with emergency preemption. It sequences GREEN, YELLOW and ALL-RED phase timing and drives a one-hot grant plus phase indication to the light-driver stage. Approach index order is fixed: 0 = north, 1 = south, 2 = east, 3 = west. Bit k of every 4-bit vector refers to approach k.

## Interface
- MIN_GREEN, 4: minimum green cycles before a normal hand-off.
- MAX_GREEN, 12: maximum green cycles while jam extends the green.
- YELLOW_T, 3: yellow cycles.
- ALLRED_T, 1: all-red clearance cycles.
- CNT_W, 5: phase timer width. It must hold MAX_GREEN.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  vehicle-present detectors, level.
- emergency  in  4  emergency request. May be a 1-cycle pulse.
- jam  in  4  congestion. Also acts as a request and extends the green.
- empty  in  4  approach cleared. Cancels pending or current service.
- grant  out  4  one-hot approach holding right-of-way. 0 in IDLE and ALLRED.
- phase  out  2  00 = IDLE, 01 = GREEN, 10 = YELLOW, 11 = ALLRED.
- preempt  out  1  1-cycle pulse when a green is cut short by emergency.
- busy  out  1  1 whenever phase != IDLE.

## Operation
- All outputs are registered. Reset values: grant = 0000, phase = 00, preempt = 0, busy = 0. Internally, pend = 0, epend = 0, timer = 0, rr_ptr = 3, so the first search starts at north.
- Request latching, every cycle:
  - pend |= (req | jam) & ~empty.
  - epend |= emergency & ~empty.
  - empty[k] clears pend[k] and epend[k]. Clear wins over set.
  - The currently granted approach is never set in pend/epend while in GREEN.
- Arbitration uses the registered pend/epend only.
  - If epend != 0, the winner is the lowest-index set bit of epend.
  - Otherwise, the winner is the first set bit of pend searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - On entry to GREEN: rr_ptr = winner, and pend[winner] and epend[winner] are cleared.
- IDLE: if pend | epend != 0, go to GREEN with grant = onehot(winner). Else stay in IDLE.
- GREEN: timer counts from 1 on the first green cycle and saturates at MAX_GREEN. `others` = (pend | epend) with the current bit excluded.
  - emergency/epend for the current approach: hold green. Timer limits are ignored.
  - epend for another approach: go to YELLOW next cycle and pulse preempt, regardless of timer.
  - empty for the current approach with timer >= MIN_GREEN: go to YELLOW.
  - timer >= MIN_GREEN, others != 0, current jam = 0: go to YELLOW.
  - timer >= MAX_GREEN and others != 0: go to YELLOW, regardless of jam.
  - Otherwise stay green. With no competing requests the green rests indefinitely.
- YELLOW: grant is unchanged. Lasts YELLOW_T cycles, then goes to ALLRED.
- ALLRED: grant = 0000. Lasts ALLRED_T cycles. Then go to GREEN for the winner if pend | epend != 0, else go to IDLE.
- Emergency arriving during YELLOW or ALLRED does not shorten clearance. It wins arbitration at ALLRED exit.

## Timing
- Request latency from IDLE: input high at edge k sets pend at k. State is GREEN with grant valid after edge k+1.
- Phase durations are exact:
  - green is at least MIN_GREEN cycles, except under preemption;
  - yellow is exactly YELLOW_T cycles;
  - all-red is exactly ALLRED_T cycles.
- Preempt latency: emergency high at edge k sets epend at k. After edge k+1, phase = YELLOW and preempt = 1 for that one cycle.
- Hand-off to a pending approach:
  - GREEN → YELLOW at the edge after the condition holds;
  - the new grant appears YELLOW_T + ALLRED_T cycles after YELLOW entry.
- Simultaneous events on the same cycle:
  - empty and req on the same approach: empty wins;
  - emergency on two approaches: the lower index is served first, the other stays in epend;
  - the approach being granted and its own request: the grant consumes the request.
- rst mid-operation: at the next edge all state returns to reset values and pending requests are discarded.

## Test plan
- Reset, then req = 0001 for 1 cycle → grant = 0001, phase = 01 two edges later. With no further requests, green is held for more than 50 cycles.
- req = 0101 together from IDLE → N green for 4 cycles, then yellow for 3 cycles (grant 0001), then all-red for 1 cycle (grant 0000), then grant = 0100 green.
- N green at timer = 2, emergency = 0010 pulsed 1 cycle → phase = 10 with preempt = 1 on the next cycle, then 3 yellow + 1 all-red, then grant = 0010. Cover the same pulse during YELLOW: clearance completes unchanged.
- N green, jam = 0001 held, req = 0010 → N green holds to exactly 12 cycles, then yellow, then S green.
- req = 1000 and empty = 1000 on the same cycle → stays IDLE. Separately, W green with no other requests, empty = 1000 after timer ≥ 4 → yellow, then all-red, then IDLE, with busy = 0.
- rst asserted for 1 cycle during YELLOW with pend = 0110 → next cycle grant = 0000, phase = 00, busy = 0, and no grant follows without new requests.
